// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding, timing limits and bus field helpers for the sweep controller.
package sweep_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_PLL_RST, S_WAIT_DROP, S_WAIT_LOCK, S_SETTLE, S_TEST, S_STEP, S_DONE
    } state_t;
    localparam int WAIT_DROP_MAX = 8;
    localparam int DROP_W = $clog2(WAIT_DROP_MAX);
    function automatic int field_lo(input int ch, input int w);
        return ch * w;
    endfunction
endpackage

// File: rtl/sweep_test_ctrl_if.sv
// sweep_test_ctrl_if: step/reset handshake between the sweep controller and the reconfigurable PLL.
interface sweep_test_ctrl_if #(parameter int FREQ_W = 9);
    logic pll_reset;
    logic next_frequency;
    logic freq_ready;
    logic [FREQ_W-1:0] frequency;
    modport master (output pll_reset, next_frequency, input freq_ready, frequency);
    modport slave (input pll_reset, next_frequency, output freq_ready, frequency);
endinterface

// File: rtl/fail_capture.sv
// fail_capture: one channel's rising-edge error counter with first-fail frequency capture.
module fail_capture #(
    parameter int FREQ_W = 9,
    parameter int FCNT_W = 11
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              error,
    input  logic              window,
    input  logic              clear,
    input  logic [FREQ_W-1:0] frequency,
    output logic              fail_valid,
    output logic [FREQ_W-1:0] fail_freq,
    output logic [FCNT_W-1:0] fail_count
);
    logic err_d;
    logic rise;
    // err_d tracks outside the window too, so a level already high on entry is not a rise
    assign rise = error & ~err_d & window;
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            err_d      <= 1'b0;
            fail_valid <= 1'b0;
            fail_freq  <= '0;
            fail_count <= '0;
        end else begin
            err_d <= error;
            if (clear) begin
                fail_valid <= 1'b0;
                fail_freq  <= '0;
                fail_count <= '0;
            end else if (rise) begin
                fail_count <= (fail_count == '1) ? fail_count : fail_count + 1'b1;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_freq  <= frequency;
                end
            end
        end
    end
endmodule

// File: rtl/sweep_test_ctrl.sv
// sweep_test_ctrl: steps the PLL through a frequency sweep and collects per-channel RAM fail results.
module sweep_test_ctrl
    import sweep_pkg::*;
#(
    parameter int                N_CH     = 4,
    parameter int                FREQ_W   = 9,
    parameter int                LEN_W    = 20,
    parameter int                FCNT_W   = 11,
    parameter int                SETTLE   = 32,
    parameter logic [FREQ_W-1:0] FREQ_MAX = '1
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     clear,
    input  logic                     stop_on_fail,
    input  logic [LEN_W-1:0]         test_length,
    input  logic [N_CH-1:0]          error,
    sweep_test_ctrl_if.master        pll,
    output logic                     busy,
    output logic                     done,
    output logic [N_CH-1:0]          fail_valid,
    output logic [N_CH*FREQ_W-1:0]   fail_freq,
    output logic [N_CH*FCNT_W-1:0]   fail_count
);
    localparam int SW = $clog2(SETTLE) + 1;
    state_t             state, state_n;
    logic [LEN_W-1:0]   test_cnt, test_cnt_n, last;
    logic [SW-1:0]      settle_cnt, settle_cnt_n;
    logic [DROP_W-1:0]  drop_cnt, drop_cnt_n;
    logic               idle_like, clr, go, window, finish;
    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign clr       = clear & ~abort & idle_like;
    assign go        = start & ~clear & ~abort & idle_like;
    assign last      = (test_length == '0) ? '0 : test_length - LEN_W'(1);
    assign window    = (state == S_TEST) && pll.freq_ready;
    assign finish    = (pll.frequency == FREQ_MAX) || (stop_on_fail && |fail_valid);
    assign busy               = !idle_like;
    assign done               = state == S_DONE;
    assign pll.pll_reset      = state == S_PLL_RST;
    assign pll.next_frequency = state == S_STEP;
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            test_cnt   <= '0;
            settle_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_n;
            test_cnt   <= test_cnt_n;
            settle_cnt <= settle_cnt_n;
            drop_cnt   <= drop_cnt_n;
        end
    end
    always_comb begin
        state_n      = state;
        test_cnt_n   = test_cnt;
        settle_cnt_n = settle_cnt;
        drop_cnt_n   = drop_cnt;
        if (abort) state_n = S_IDLE;
        else case (state)
            S_IDLE, S_DONE: state_n = go ? S_PLL_RST : state;
            S_PLL_RST:      state_n = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                test_cnt_n   = '0;
                settle_cnt_n = '0;
                state_n      = pll.freq_ready ? S_SETTLE : S_WAIT_LOCK;
            end
            S_SETTLE: begin
                settle_cnt_n = pll.freq_ready ? settle_cnt + 1'b1 : '0;
                state_n      = (pll.freq_ready && settle_cnt == SW'(SETTLE - 1)) ? S_TEST : S_SETTLE;
            end
            // a lock loss mid-dwell resettles but resumes at the held test_cnt
            S_TEST: begin
                if (!pll.freq_ready) begin
                    state_n      = S_SETTLE;
                    settle_cnt_n = '0;
                end else if (test_cnt == last) state_n = finish ? S_DONE : S_STEP;
                else test_cnt_n = test_cnt + 1'b1;
            end
            S_STEP: begin
                drop_cnt_n = '0;
                state_n    = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                drop_cnt_n = drop_cnt + 1'b1;
                state_n    = (!pll.freq_ready || drop_cnt == DROP_W'(WAIT_DROP_MAX - 1)) ? S_WAIT_LOCK : S_WAIT_DROP;
            end
            default: state_n = S_IDLE;
        endcase
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        fail_capture #(.FREQ_W(FREQ_W), .FCNT_W(FCNT_W)) u_cap (
            .CLOCK_50   (CLOCK_50),
            .reset_n    (reset_n),
            .error      (error[i]),
            .window     (window),
            .clear      (clr),
            .frequency  (pll.frequency),
            .fail_valid (fail_valid[i]),
            .fail_freq  (fail_freq[field_lo(i, FREQ_W) +: FREQ_W]),
            .fail_count (fail_count[field_lo(i, FCNT_W) +: FCNT_W])
        );
    end
endmodule

// File: tb/tb_sweep_test_ctrl.sv
// tb_sweep_test_ctrl: directed scenario bench for sweep_test_ctrl with a simple PLL lock model.
module tb_sweep_test_ctrl;
    import sweep_pkg::*;
    localparam int N_CH = 4, FREQ_W = 9, LEN_W = 20, FCNT_W = 3;
    logic CLOCK_50 = 0, reset_n = 0, start = 0, abort = 0, clear = 0, stop_on_fail = 0;
    logic [LEN_W-1:0] test_length = 4;
    logic [N_CH-1:0] error = '0;
    logic busy, done;
    logic [N_CH-1:0] fail_valid;
    logic [N_CH*FREQ_W-1:0] fail_freq;
    logic [N_CH*FCNT_W-1:0] fail_count;
    logic [FREQ_W-1:0] base = '0, freq = '0;
    logic [2:0] lock_cnt = '0;
    logic force_drop = 0;
    int checks = 0, errors = 0;
    int nf_total = 0, pr_total = 0, test_total = 0;
    sweep_test_ctrl_if #(.FREQ_W(FREQ_W)) pll();
    sweep_test_ctrl #(.N_CH(N_CH), .FREQ_W(FREQ_W), .LEN_W(LEN_W), .FCNT_W(FCNT_W),
                      .SETTLE(32), .FREQ_MAX(9'h1FF)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .abort(abort), .clear(clear),
        .stop_on_fail(stop_on_fail), .test_length(test_length), .error(error), .pll(pll),
        .busy(busy), .done(done), .fail_valid(fail_valid), .fail_freq(fail_freq), .fail_count(fail_count));
    always #5 CLOCK_50 = ~CLOCK_50;
    // PLL model: relock 3 cycles after reset, 2 cycles after a step
    always @(posedge CLOCK_50) begin
        if (pll.pll_reset) begin freq <= base; lock_cnt <= 3'd3; end
        else if (pll.next_frequency) begin freq <= freq + 1'b1; lock_cnt <= 3'd2; end
        else if (lock_cnt != 0) lock_cnt <= lock_cnt - 1'b1;
    end
    assign pll.frequency  = freq;
    assign pll.freq_ready = (lock_cnt == 0) && !force_drop;
    always @(posedge CLOCK_50) begin
        nf_total   <= nf_total + int'(pll.next_frequency);
        pr_total   <= pr_total + int'(pll.pll_reset);
        test_total <= test_total + int'(dut.state == S_TEST);
    end
    function automatic logic [FCNT_W-1:0] cnt(input int i);
        return fail_count[i*FCNT_W +: FCNT_W];
    endfunction
    function automatic logic [FREQ_W-1:0] ff(input int i);
        return fail_freq[i*FREQ_W +: FREQ_W];
    endfunction
    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLOCK_50);
    endtask
    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask
    task automatic wait_test(input logic [FREQ_W-1:0] f);
        int n = 0;
        while (!(dut.state == S_TEST && freq == f) && n < 5000) begin tick(); n++; end
        checks++; if (n >= 5000) begin errors++; $display("FAIL wait_test: timeout waiting for TEST at %h", f); end
    endtask
    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin tick(); n++; end
        checks++; if (n >= 5000) begin errors++; $display("FAIL wait_done: timeout, done=%b", done); end
    endtask
    task automatic abort_and_clear();
        abort = 1; tick(); abort = 0; tick();
        clear = 1; tick(); clear = 0; tick();
    endtask
    task automatic test_reset();
        tick(2);
        checks++; if ({busy, done, pll.pll_reset, pll.next_frequency} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, pll.pll_reset, pll.next_frequency}); end
        checks++; if ({fail_valid, fail_freq, fail_count} !== '0) begin errors++; $display("FAIL reset_results: got %h want 0", {fail_valid, fail_freq, fail_count}); end
        reset_n = 1; tick();
    endtask
    task automatic test_no_error_sweep();
        int nf0, t0, p0;
        base = 9'h1FC; test_length = 4; stop_on_fail = 0;
        nf0 = nf_total; t0 = test_total; p0 = pr_total;
        pulse_start();
        checks++; if (pll.pll_reset !== 1'b1) begin errors++; $display("FAIL start_pll_reset: got %b want 1", pll.pll_reset); end
        wait_done(); tick(2);
        checks++; if (nf_total - nf0 != 3) begin errors++; $display("FAIL sweep_steps: got %0d want 3", nf_total - nf0); end
        checks++; if (test_total - t0 != 16) begin errors++; $display("FAIL sweep_dwell: got %0d want 16", test_total - t0); end
        checks++; if (pr_total - p0 != 1) begin errors++; $display("FAIL sweep_pll_reset: got %0d want 1", pr_total - p0); end
        checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL sweep_done: got %b want 10", {done, busy}); end
        checks++; if (freq !== 9'h1FF) begin errors++; $display("FAIL sweep_last_freq: got %h want 1ff", freq); end
        checks++; if ({fail_valid, fail_count} !== '0) begin errors++; $display("FAIL sweep_counts: got %h want 0", {fail_valid, fail_count}); end
        base = 9'h1FF; test_length = 0;
        nf0 = nf_total; t0 = test_total;
        pulse_start(); wait_done(); tick(2);
        checks++; if (test_total - t0 != 1) begin errors++; $display("FAIL len0_dwell: got %0d want 1", test_total - t0); end
        checks++; if (nf_total - nf0 != 0) begin errors++; $display("FAIL len0_steps: got %0d want 0", nf_total - nf0); end
    endtask
    task automatic test_single_error();
        base = 9'h0A5; test_length = 40; stop_on_fail = 0;
        pulse_start(); wait_test(9'h0A5);
        tick(3); error = 4'b0100; tick(); error = '0;
        wait_test(9'h0A6);
        tick(3); error = 4'b0100; tick(); error = '0; tick(2);
        checks++; if (ff(2) !== 9'h0A5) begin errors++; $display("FAIL single_freq: got %h want 0a5", ff(2)); end
        checks++; if (fail_valid !== 4'b0100) begin errors++; $display("FAIL single_valid: got %b want 0100", fail_valid); end
        checks++; if (cnt(2) !== 3'd2) begin errors++; $display("FAIL single_count: got %0d want 2", cnt(2)); end
        checks++; if ({cnt(0), cnt(1), cnt(3)} !== '0) begin errors++; $display("FAIL single_others: got %h want 0", {cnt(0), cnt(1), cnt(3)}); end
    endtask
    task automatic test_abort_clear();
        abort = 1; tick(); abort = 0;
        checks++; if (dut.state !== S_IDLE || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle: state %0d busy %b done %b want IDLE 0 0", dut.state, busy, done); end
        checks++; if (cnt(2) !== 3'd2 || fail_valid !== 4'b0100) begin errors++; $display("FAIL abort_retain: count %0d valid %b want 2 0100", cnt(2), fail_valid); end
        tick(2); clear = 1; tick(); clear = 0;
        checks++; if ({fail_valid, fail_freq, fail_count} !== '0) begin errors++; $display("FAIL clear_results: got %h want 0", {fail_valid, fail_freq, fail_count}); end
    endtask
    task automatic test_stop_on_fail();
        int nf0, p0;
        base = 9'h010; test_length = 20; stop_on_fail = 1;
        nf0 = nf_total;
        pulse_start(); wait_test(9'h010);
        tick(2); error = 4'b1001; tick(); error = '0;
        wait_done(); tick(2);
        checks++; if (cnt(0) !== 3'd1 || cnt(3) !== 3'd1 || cnt(1) !== 3'd0) begin errors++; $display("FAIL simul_counts: got %0d %0d %0d want 1 1 0", cnt(0), cnt(3), cnt(1)); end
        checks++; if (fail_valid !== 4'b1001) begin errors++; $display("FAIL simul_valid: got %b want 1001", fail_valid); end
        checks++; if (ff(0) !== 9'h010 || ff(3) !== 9'h010) begin errors++; $display("FAIL simul_freq: got %h %h want 010 010", ff(0), ff(3)); end
        checks++; if (nf_total - nf0 != 0 || freq !== 9'h010) begin errors++; $display("FAIL stop_steps: steps %0d freq %h want 0 010", nf_total - nf0, freq); end
        p0 = pr_total;
        start = 1; clear = 1; tick(); start = 0; clear = 0; tick(2);
        checks++; if (done !== 1'b1 || pr_total - p0 != 0) begin errors++; $display("FAIL start_clear: done %b pulses %0d want 1 0", done, pr_total - p0); end
        checks++; if ({fail_valid, fail_count} !== '0) begin errors++; $display("FAIL start_clear_results: got %h want 0", {fail_valid, fail_count}); end
        stop_on_fail = 0;
    endtask
    task automatic test_drop_mid_test();
        int n = 0, t0;
        base = 9'h020; test_length = 20;
        t0 = test_total;
        pulse_start(); wait_test(9'h020);
        tick(10);
        checks++; if (dut.test_cnt !== 20'd10) begin errors++; $display("FAIL drop_pre_cnt: got %0d want 10", dut.test_cnt); end
        force_drop = 1; tick();
        checks++; if (dut.state !== S_SETTLE || dut.test_cnt !== 20'd10) begin errors++; $display("FAIL drop_settle: state %0d cnt %0d want SETTLE 10", dut.state, dut.test_cnt); end
        error = 4'b0010; tick(2); error = '0; tick();
        force_drop = 0;
        while (dut.state != S_TEST && n < 100) begin tick(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL drop_resettle: got %0d want 32", n); end
        checks++; if (dut.test_cnt !== 20'd10) begin errors++; $display("FAIL drop_resume_cnt: got %0d want 10", dut.test_cnt); end
        n = 0;
        while (dut.state == S_TEST && n < 100) begin tick(); n++; end
        tick(2);
        checks++; if (test_total - t0 != 21) begin errors++; $display("FAIL drop_dwell: got %0d want 21", test_total - t0); end
        checks++; if (cnt(1) !== 3'd0 || fail_valid !== 4'b0) begin errors++; $display("FAIL drop_no_count: count %0d valid %b want 0 0", cnt(1), fail_valid); end
        abort_and_clear();
    endtask
    task automatic test_saturation_hold();
        base = 9'h030; test_length = 100;
        pulse_start(); wait_test(9'h030);
        tick(2);
        repeat (10) begin error[1] = 1; tick(); error[1] = 0; tick(); end
        tick();
        checks++; if (cnt(1) !== 3'd7) begin errors++; $display("FAIL saturate: got %0d want 7", cnt(1)); end
        checks++; if (fail_valid !== 4'b0010 || ff(1) !== 9'h030) begin errors++; $display("FAIL saturate_capture: valid %b freq %h want 0010 030", fail_valid, ff(1)); end
        error[0] = 1; tick(100); error[0] = 0; tick(2);
        checks++; if (cnt(0) !== 3'd1 || ff(0) !== 9'h030) begin errors++; $display("FAIL hold_once: count %0d freq %h want 1 030", cnt(0), ff(0)); end
        abort_and_clear();
    endtask
    task automatic test_reset_in_step();
        int n = 0;
        base = 9'h040; test_length = 4;
        pulse_start(); wait_test(9'h040);
        error[3] = 1; tick(); error[3] = 0;
        while (!pll.next_frequency && n < 200) begin tick(); n++; end
        checks++; if (fail_valid !== 4'b1000 || pll.next_frequency !== 1'b1) begin errors++; $display("FAIL pre_reset: valid %b nf %b want 1000 1", fail_valid, pll.next_frequency); end
        #1 reset_n = 0; #1;
        checks++; if (pll.next_frequency !== 1'b0 || pll.pll_reset !== 1'b0) begin errors++; $display("FAIL reset_pulse: nf %b pr %b want 0 0", pll.next_frequency, pll.pll_reset); end
        checks++; if ({busy, done, fail_valid, fail_freq, fail_count} !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {busy, done, fail_valid, fail_freq, fail_count}); end
        tick(2); reset_n = 1; tick();
    endtask
    initial begin
        test_reset();
        test_no_error_sweep();
        test_single_error();
        test_abort_clear();
        test_stop_on_fail();
        test_drop_mid_test();
        test_saturation_hold();
        test_reset_in_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
